imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the 16 KB instruction memory. Consumes the byte stream from the UART receiver, frames it (magic, length, payload, checksum), packs payload bytes into little-endian 32-bit words, and drives the instruction memory write port starting at 0x8000_0000. Holds the core out of fetch (`cpu_hold`) until an image has been loaded successfully.

## Interface

Parameters:
- `BASE_ADDR`, 32'h8000_0000: address of payload byte 0.
- `MEM_BYTES`, 16384: instruction memory size; longer images are rejected.
- `MAGIC`, 8'hA5: frame start byte.

Ports:
- `clk`, in, 1: single clock; all logic on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `rx_data`, in, 8: received byte.
- `rx_valid`, in, 1: one-cycle strobe; `rx_data` is valid. There is no backpressure, so every strobe is consumed.
- `wr_en`, out, 1: one-cycle write strobe to instruction memory.
- `wr_addr`, out, 32: word-aligned byte address.
- `wr_data`, out, 32: little-endian word; byte 0 is at `wr_addr`.
- `wr_strb`, out, 4: byte enables; bit i corresponds to `wr_data[8i+7:8i]`.
- `cpu_hold`, out, 1: core stalled or held in reset while high.
- `busy`, out, 1: frame in progress.
- `done`, out, 1: last frame loaded OK; level signal.
- `error`, out, 1: last frame rejected; level signal.

## Operation

- States: IDLE, LEN, PAYLOAD, CKSUM.
- **IDLE:** a byte equal to `MAGIC` moves to LEN. It also clears `done`/`error`, sets `busy` and `cpu_hold`, and zeroes the byte counter and checksum. Any other byte is ignored.
- **LEN:** accepts 4 bytes, little-endian, as 32-bit `len` (payload byte count).
  - After the 4th byte:
    - `len > MEM_BYTES`: set `error`, go to IDLE.
    - `len == 0`: go to CKSUM.
    - Otherwise: go to PAYLOAD.
- **PAYLOAD:** each byte goes into lane `cnt[1:0]` of the packing register, sets that strobe bit, adds to the 8-bit checksum (mod 256), and increments `cnt`.
  - A write is issued when lane 3 fills or `cnt+1 == len`.
  - `wr_addr = BASE_ADDR + {cnt[31:2], 2'b00}`.
  - `wr_strb` is the accumulated lanes: 4'b1111 for full words; 4'b0001, 4'b0011 or 4'b0111 for a final partial word.
  - The packing register and strobes clear after each write.
  - Go to CKSUM after the last byte.
- **CKSUM:** accepts 1 byte and compares it with the checksum (see Configuration).
  - Match: `done`=1, `cpu_hold`=0.
  - Mismatch: `error`=1, `cpu_hold` stays 1.
  - Always returns to IDLE with `busy`=0.
- Memory writes are never rolled back; on error, partial image contents remain in memory.
- A new `MAGIC` byte in IDLE after `done` or `error` starts a reload and re-asserts `cpu_hold`. Bytes arriving during LEN, PAYLOAD or CKSUM are always data, including values equal to `MAGIC`.

## Timing

- Reset values:
  - `wr_en`=0, `wr_addr`=`BASE_ADDR`, `wr_data`=0, `wr_strb`=0
  - `busy`=0, `done`=0, `error`=0, `cpu_hold`=1
  - state IDLE
- All outputs are registered.
- `wr_en` is high for exactly one cycle, in the cycle after the byte that completes a word is accepted. `wr_addr`/`wr_data`/`wr_strb` are valid only while `wr_en`=1.
- Throughput: one byte per cycle sustained, so back-to-back `rx_valid` is legal. At that rate a full word yields `wr_en` every 4th cycle.
- `done`/`error`/`cpu_hold` update in the cycle after the checksum byte is accepted.
- Rejection for `len > MEM_BYTES` is flagged in the cycle after the 4th length byte.
- Asynchronous reset mid-frame:
  - Aborts immediately to IDLE with the reset values above; a pending partial word is dropped.
  - `cpu_hold` returns to 1.

## Configuration

- `IMEM_LOADER_CKSUM_EN` defined: checksum is accumulated and compared as above.
- Not defined:
  - The accumulator is removed.
  - The CKSUM byte is still consumed but ignored.
  - Every frame that passes the length check ends with `done`=1 and `cpu_hold`=0.

## Structure

- Package `imem_loader_pkg`:
  - state enum `loader_state_e` (IDLE, LEN, PAYLOAD, CKSUM)
  - default constants `IMEM_BASE_ADDR` (32'h8000_0000), `IMEM_BYTES` (16384), `LOADER_MAGIC` (8'hA5)
- One sub-module is natural: `imem_word_packer`.
  - Function: lane insert, strobe accumulate, flush on full or last, `wr_*` output registers.
  - Controls: `push`, `last`, `clr`.
- The framing FSM, counters and checksum stay in `imem_loader`.

## Test plan

- **Reset state:** after reset, check every output reset value; `cpu_hold`=1.
- **Full-word image:** A5, 08 00 00 00, 13 00 00 00 6F 00 00 00, checksum 0x82, fed back-to-back.
  - Expected: writes (0x8000_0000, 0x0000_0013, 4'hF) and (0x8000_0004, 0x0000_006F, 4'hF).
  - Then `done`=1, `cpu_hold`=0.
- **Partial tail:** A5, len 5, 11 22 33 44 55, checksum 0xFF.
  - Expected: second write is (0x8000_0004, 0x0000_0055, 4'b0001); `done`=1.
- **Bad checksum / bad length:**
  - Same as the full-word image but with checksum 0x00: `error`=1, `cpu_hold`=1, both writes still issued. Without `IMEM_LOADER_CKSUM_EN`: `done`=1.
  - Length 0x0000_4001: `error`=1, no writes.
- **Stray bytes and embedded magic:**
  - Bytes 00 FF before A5 are ignored.
  - An A5 inside the payload is written as data.
- **Reset mid-frame:** assert `rst_n`=0 after 6 payload bytes.
  - Expected: state IDLE, no further `wr_en`, `cpu_hold`=1.
  - A subsequent full frame loads normally.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and default constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2,
    CKSUM   = 2'd3
  } loader_state_e;

  localparam logic [31:0] IMEM_BASE_ADDR = 32'h8000_0000;
  localparam int          IMEM_BYTES     = 16384;
  localparam logic [7:0]  LOADER_MAGIC   = 8'hA5;

  function automatic logic [3:0] lane_mask(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction memory write port and status bundle of the loader.
interface imem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    output rx_data, rx_valid,
    input  wr_en, wr_addr, wr_data, wr_strb, cpu_hold, busy, done, error
  );

  modport slave (
    input  rx_data, rx_valid,
    output wr_en, wr_addr, wr_data, wr_strb, cpu_hold, busy, done, error
  );
endinterface

// File: rtl/imem_word_packer.sv
// Packs payload bytes into little-endian words and registers the memory write port.
// A word is flushed when lane 3 fills or on the last payload byte.
module imem_word_packer
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = IMEM_BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  logic        last_i,
  input  logic        clr_i,
  input  logic [7:0]  byte_i,
  input  logic [31:0] cnt_i,
  output logic        wr_en_o,
  output logic [31:0] wr_addr_o,
  output logic [31:0] wr_data_o,
  output logic [3:0]  wr_strb_o
);

  logic [31:0] pack_q, pack_d;
  logic [3:0]  strb_q, strb_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [3:0]  wr_strb_q, wr_strb_d;

  logic [1:0]  lane;
  logic [31:0] pack_ins;
  logic [3:0]  strb_ins;

  assign lane     = cnt_i[1:0];
  assign pack_ins = pack_q | ({24'h0, byte_i} << {lane, 3'b000});
  assign strb_ins = strb_q | lane_mask(lane);

  always_comb begin
    pack_d    = pack_q;
    strb_d    = strb_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_strb_d = wr_strb_q;
    if (clr_i) begin
      pack_d = '0;
      strb_d = '0;
    end else if (push_i) begin
      if (lane == 2'd3 || last_i) begin
        wr_en_d   = 1'b1;
        wr_addr_d = BASE_ADDR + {cnt_i[31:2], 2'b00};
        wr_data_d = pack_ins;
        wr_strb_d = strb_ins;
        pack_d    = '0;
        strb_d    = '0;
      end else begin
        pack_d = pack_ins;
        strb_d = strb_ins;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_q    <= '0;
      strb_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= BASE_ADDR;
      wr_data_q <= '0;
      wr_strb_q <= '0;
    end else begin
      pack_q    <= pack_d;
      strb_q    <= strb_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_strb_q <= wr_strb_d;
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign wr_strb_o = wr_strb_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: frames the UART byte stream and writes the image into instruction memory.
// Define IMEM_LOADER_CKSUM_EN to accumulate and verify the 8-bit payload checksum.
//
// state   | meaning
// IDLE    | waiting for MAGIC; other bytes ignored
// LEN     | collecting 4 little-endian length bytes
// PAYLOAD | packing payload bytes and writing words
// CKSUM   | consuming the checksum byte, then reporting done/error
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = IMEM_BASE_ADDR,
  parameter int          MEM_BYTES = IMEM_BYTES,
  parameter logic [7:0]  MAGIC     = LOADER_MAGIC
) (
  input logic          clk,
  input logic          rst_n,
  imem_loader_if.slave bus
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  loader_state_e state_q, state_d;
  logic [31:0]   len_q, len_d;
  logic [1:0]    lenb_q, lenb_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          hold_q, hold_d;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]    cksum_q, cksum_d;
`endif

  logic push, last, clr;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    lenb_d  = lenb_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    error_d = error_q;
    hold_d  = hold_q;
    push    = 1'b0;
    last    = 1'b0;
    clr     = 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
    cksum_d = cksum_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.rx_valid && bus.rx_data == MAGIC) begin
          state_d = LEN;
          done_d  = 1'b0;
          error_d = 1'b0;
          busy_d  = 1'b1;
          hold_d  = 1'b1;
          cnt_d   = '0;
          lenb_d  = '0;
          clr     = 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
          cksum_d = '0;
`endif
        end
      end
      LEN: begin
        if (bus.rx_valid) begin
          // Shift in from the top so the first byte ends up in bits [7:0].
          len_d  = {bus.rx_data, len_q[31:8]};
          lenb_d = lenb_q + 2'd1;
          if (lenb_q == 2'd3) begin
            if (len_d > MEM_LIMIT) begin
              error_d = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end else if (len_d == '0) begin
              state_d = CKSUM;
            end else begin
              state_d = PAYLOAD;
            end
          end
        end
      end
      PAYLOAD: begin
        if (bus.rx_valid) begin
          push  = 1'b1;
          last  = (cnt_q + 32'd1 == len_q);
          cnt_d = cnt_q + 32'd1;
`ifdef IMEM_LOADER_CKSUM_EN
          cksum_d = cksum_q + bus.rx_data;
`endif
          if (last) state_d = CKSUM;
        end
      end
      CKSUM: begin
        if (bus.rx_valid) begin
          busy_d  = 1'b0;
          state_d = IDLE;
`ifdef IMEM_LOADER_CKSUM_EN
          if (bus.rx_data == cksum_q) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            error_d = 1'b1;
          end
`else
          done_d = 1'b1;
          hold_d = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      lenb_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      hold_q  <= 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
      cksum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      lenb_q  <= lenb_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      hold_q  <= hold_d;
`ifdef IMEM_LOADER_CKSUM_EN
      cksum_q <= cksum_d;
`endif
    end
  end

  logic        pk_wr_en;
  logic [31:0] pk_wr_addr;
  logic [31:0] pk_wr_data;
  logic [3:0]  pk_wr_strb;

  imem_word_packer #(
    .BASE_ADDR (BASE_ADDR)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .last_i    (last),
    .clr_i     (clr),
    .byte_i    (bus.rx_data),
    .cnt_i     (cnt_q),
    .wr_en_o   (pk_wr_en),
    .wr_addr_o (pk_wr_addr),
    .wr_data_o (pk_wr_data),
    .wr_strb_o (pk_wr_strb)
  );

  assign bus.wr_en    = pk_wr_en;
  assign bus.wr_addr  = pk_wr_addr;
  assign bus.wr_data  = pk_wr_data;
  assign bus.wr_strb  = pk_wr_strb;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.error    = error_q;
  assign bus.cpu_hold = hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed frame vectors plus reset/reload sequences for imem_loader.
module tb_imem_loader;
  localparam logic [31:0] BASE = 32'h8000_0000;
`ifdef IMEM_LOADER_CKSUM_EN
  localparam logic CK = 1'b1;
`else
  localparam logic CK = 1'b0;
`endif
  localparam int NV = 7;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  imem_loader_if bus ();

  imem_loader u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Captured memory writes
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [3:0]  ws_q[$];
  int          wc_q[$];

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wa_q.push_back(bus.wr_addr);
      wd_q.push_back(bus.wr_data);
      ws_q.push_back(bus.wr_strb);
      wc_q.push_back(cyc);
    end
  end

  // bytes are written first-byte-leftmost; byte i sits at bits 8*(n-1-i)
  typedef struct packed {
    logic [127:0] bytes;
    logic [4:0]   n;
    logic [1:0]   nw;
    logic [31:0]  wa0;
    logic [31:0]  wd0;
    logic [3:0]   ws0;
    logic [31:0]  wa1;
    logic [31:0]  wd1;
    logic [3:0]   ws1;
    logic         e_done;
    logic         e_err;
    logic         e_hold;
  } vec_t;

  vec_t v [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic clear_wr();
    wa_q.delete();
    wd_q.delete();
    ws_q.delete();
    wc_q.delete();
  endtask

  task automatic apply_vec(input int k);
    int n;
    n = int'(v[k].n);
    clear_wr();
    for (int i = 0; i < n; i++) send(v[k].bytes[8*(n-1-i) +: 8]);
    idle();
    chk($sformatf("v%0d done", k),     32'(bus.done),     32'(v[k].e_done));
    chk($sformatf("v%0d error", k),    32'(bus.error),    32'(v[k].e_err));
    chk($sformatf("v%0d cpu_hold", k), 32'(bus.cpu_hold), 32'(v[k].e_hold));
    chk($sformatf("v%0d busy", k),     32'(bus.busy),     32'd0);
    chk($sformatf("v%0d nwrites", k),  32'(wa_q.size()),  32'(v[k].nw));
    for (int j = 0; j < int'(v[k].nw); j++) begin
      if (wa_q.size() > j) begin
        chk($sformatf("v%0d w%0d addr", k, j), wa_q[j], (j == 0) ? v[k].wa0 : v[k].wa1);
        chk($sformatf("v%0d w%0d data", k, j), wd_q[j], (j == 0) ? v[k].wd0 : v[k].wd1);
        chk($sformatf("v%0d w%0d strb", k, j), 32'(ws_q[j]), 32'((j == 0) ? v[k].ws0 : v[k].ws1));
      end
    end
    if (k == 0 && wc_q.size() == 2)
      chk("v0 write spacing", 32'(wc_q[1] - wc_q[0]), 32'd4);
  endtask

  initial begin
    v[0] = '{128'hA5_08_00_00_00_13_00_00_00_6F_00_00_00_82, 5'd14, 2'd2,
             BASE, 32'h0000_0013, 4'hF, BASE + 32'd4, 32'h0000_006F, 4'hF, 1'b1, 1'b0, 1'b0};
    v[1] = '{128'hA5_05_00_00_00_11_22_33_44_55_FF, 5'd11, 2'd2,
             BASE, 32'h4433_2211, 4'hF, BASE + 32'd4, 32'h0000_0055, 4'b0001, 1'b1, 1'b0, 1'b0};
    v[2] = '{128'hA5_08_00_00_00_13_00_00_00_6F_00_00_00_00, 5'd14, 2'd2,
             BASE, 32'h0000_0013, 4'hF, BASE + 32'd4, 32'h0000_006F, 4'hF, ~CK, CK, CK};
    v[3] = '{128'hA5_01_40_00_00, 5'd5, 2'd0,
             32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1};
    v[4] = '{128'h00_FF_A5_03_00_00_00_A5_01_02_A8, 5'd11, 2'd1,
             BASE, 32'h0002_01A5, 4'b0111, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0};
    v[5] = '{128'hA5_00_00_00_00_00, 5'd6, 2'd0,
             32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0};
    v[6] = '{128'hA5_06_00_00_00_01_02_03_04_05_06_15, 5'd12, 2'd2,
             BASE, 32'h0403_0201, 4'hF, BASE + 32'd4, 32'h0000_0605, 4'b0011, 1'b1, 1'b0, 1'b0};

    rst_n        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("rst wr_en",    32'(bus.wr_en),    32'd0);
    chk("rst wr_addr",  bus.wr_addr,       BASE);
    chk("rst wr_data",  bus.wr_data,       32'd0);
    chk("rst wr_strb",  32'(bus.wr_strb),  32'd0);
    chk("rst busy",     32'(bus.busy),     32'd0);
    chk("rst done",     32'(bus.done),     32'd0);
    chk("rst error",    32'(bus.error),    32'd0);
    chk("rst cpu_hold", 32'(bus.cpu_hold), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < NV; k++) apply_vec(k);

    // Reload after done: magic re-asserts hold and busy, clears done
    send(8'hA5);
    idle();
    chk("reload busy",     32'(bus.busy),     32'd1);
    chk("reload cpu_hold", 32'(bus.cpu_hold), 32'd1);
    chk("reload done",     32'(bus.done),     32'd0);
    for (int i = 0; i < 5; i++) send(8'h00);
    idle();
    chk("reload len0 done", 32'(bus.done), 32'd1);

    // Reset after 6 payload bytes of an 8-byte frame
    clear_wr();
    send(8'hA5);
    send(8'h08); send(8'h00); send(8'h00); send(8'h00);
    for (int i = 1; i <= 6; i++) send(8'(i));
    @(negedge clk);
    bus.rx_valid = 1'b0;
    rst_n        = 1'b0;
    #1;
    chk("midrst pre writes", 32'(wa_q.size()), 32'd1);
    chk("midrst busy",     32'(bus.busy),     32'd0);
    chk("midrst cpu_hold", 32'(bus.cpu_hold), 32'd1);
    chk("midrst wr_en",    32'(bus.wr_en),    32'd0);
    chk("midrst wr_strb",  32'(bus.wr_strb),  32'd0);
    chk("midrst wr_addr",  bus.wr_addr,       BASE);
    @(negedge clk);
    rst_n = 1'b1;
    clear_wr();
    send(8'h07); send(8'h08); send(8'h24);
    idle();
    repeat (4) @(negedge clk);
    chk("midrst post writes", 32'(wa_q.size()), 32'd0);
    chk("midrst post busy",   32'(bus.busy),    32'd0);
    chk("midrst post hold",   32'(bus.cpu_hold), 32'd1);
    chk("midrst post done",   32'(bus.done),    32'd0);
    apply_vec(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
